// File: rtl/wb_trace_checker.sv
// wb_trace_checker: checks W-stage retire events against golden trace records.
// Define WB_CHECK_HALT_ON_FAIL_EN to stop checking at the first mismatch.
module wb_trace_checker #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_valid,
    input  logic [31:0]       w_pc,
    input  logic              w_enable,
    input  logic [4:0]        w_destination,
    input  logic [31:0]       w_data,
    output logic              exp_rd,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [69:0]       exp_rdata,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              mismatch,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic              overflow,
    output logic              extra_retire,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]    PTR_ONE = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    rec_t fifo_mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic drop;

    rec_t w_rec;
    rec_t head;
    rec_t gold;
    logic [ADDR_W-1:0] idx;

    logic is_sentinel;
    logic pc_ok;
    logic rd_ok;
    logic data_ok;
    logic rec_match;
    logic do_compare;

    assign w_rec = {w_pc, w_enable, w_destination, w_data};
    assign gold  = {exp_rdata[69:38], exp_rdata[5], exp_rdata[4:0], exp_rdata[37:6]};
    assign head  = fifo_mem[rd_ptr[PTR_W-1:0]];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign push = w_valid && (state != DONE) && (!fifo_full || pop);
    assign drop = w_valid && (state != DONE) && fifo_full && !pop;

    assign is_sentinel = (gold.pc == 32'hFFFF_FFFF);

    // x0 writes carry no architectural data, so only pc/en/rd matter there.
    assign pc_ok     = (head.pc == gold.pc) && (head.en == gold.en);
    assign rd_ok     = !gold.en || (head.rd == gold.rd);
    assign data_ok   = !gold.en || (gold.rd == 5'd0) || (head.data == gold.data);
    assign rec_match = pc_ok && rd_ok && data_ok;

    assign exp_addr = idx;
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        exp_rd     = 1'b0;
        pop        = 1'b0;
        do_compare = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    exp_rd   = 1'b1;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                if (is_sentinel) begin
                    state_nx = DONE;
                end else begin
                    do_compare = 1'b1;
`ifdef WB_CHECK_HALT_ON_FAIL_EN
                    if (rec_match) begin
                        pop      = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = DONE;
                    end
`else
                    pop      = 1'b1;
                    state_nx = IDLE;
`endif
                end
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= w_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            idx    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                idx    <= idx + IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pass_count     <= '0;
            fail_count     <= '0;
            mismatch       <= 1'b0;
            first_fail_idx <= '0;
        end else if (do_compare) begin
            if (rec_match) begin
                if (pass_count != '1) begin
                    pass_count <= pass_count + CNT_ONE;
                end
            end else begin
                if (fail_count != '1) begin
                    fail_count <= fail_count + CNT_ONE;
                end
                if (!mismatch) begin
                    mismatch       <= 1'b1;
                    first_fail_idx <= idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow     <= 1'b0;
            extra_retire <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (w_valid && (state == DONE)) begin
                extra_retire <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed stimulus, queue-based reference model,
// per-cycle output comparison plus hand-computed expectations.
module tb_wb_trace_checker;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              w_valid = 1'b0;
    logic [31:0]       w_pc = '0;
    logic              w_enable = 1'b0;
    logic [4:0]        w_destination = '0;
    logic [31:0]       w_data = '0;
    logic              exp_rd;
    logic [ADDR_W-1:0] exp_addr;
    logic [69:0]       exp_rdata = '0;
    logic [CNT_W-1:0]  pass_count;
    logic [CNT_W-1:0]  fail_count;
    logic              mismatch;
    logic [ADDR_W-1:0] first_fail_idx;
    logic              overflow;
    logic              extra_retire;
    logic              done;

    wb_trace_checker #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .w_valid(w_valid),
        .w_pc(w_pc),
        .w_enable(w_enable),
        .w_destination(w_destination),
        .w_data(w_data),
        .exp_rd(exp_rd),
        .exp_addr(exp_addr),
        .exp_rdata(exp_rdata),
        .pass_count(pass_count),
        .fail_count(fail_count),
        .mismatch(mismatch),
        .first_fail_idx(first_fail_idx),
        .overflow(overflow),
        .extra_retire(extra_retire),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [69:0] gmem [64];

    always @(posedge clk) begin
        if (exp_rd) exp_rdata <= gmem[exp_addr[5:0]];
    end

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic        en;
        logic [4:0]  rd;
        logic [31:0] d;
    } ev_t;

    ev_t q[$];
    bit  busy, mdone, mmm, movf, mext;
    int  midx, mpass, mfail, mffi;
    bit  m_pop, m_was_done, m_ok;
    int  m_sz;
    logic [69:0] mg;

    function automatic bit rec_ok(input logic [69:0] g, input ev_t e);
        logic [31:0] gpc;
        logic [31:0] gd;
        logic        gen;
        logic [4:0]  grd;
        gpc = g[69:38];
        gd  = g[37:6];
        gen = g[5];
        grd = g[4:0];
        if (gpc != e.pc || gen != e.en) return 0;
        if (gen && grd != e.rd) return 0;
        if (gen && grd != 0 && gd != e.d) return 0;
        return 1;
    endfunction

    // Reference model: golden records consumed one per two cycles.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            busy = 0; mdone = 0; mmm = 0; movf = 0; mext = 0;
            midx = 0; mpass = 0; mfail = 0; mffi = 0;
        end else begin
            m_pop = 0;
            m_was_done = mdone;
            m_sz = q.size();
            if (busy) begin
                busy = 0;
                mg = gmem[midx % 64];
                if (mg[69:38] == 32'hFFFF_FFFF) begin
                    mdone = 1;
                end else begin
                    m_ok = rec_ok(mg, q[0]);
                    if (m_ok) begin
                        if (mpass < CMAX) mpass++;
                    end else begin
                        if (mfail < CMAX) mfail++;
                        if (!mmm) begin
                            mmm = 1;
                            mffi = midx;
                        end
                    end
`ifdef WB_CHECK_HALT_ON_FAIL_EN
                    if (!m_ok) mdone = 1;
                    else m_pop = 1;
`else
                    m_pop = 1;
`endif
                    if (m_pop) midx = (midx + 1) % 65536;
                end
            end else if (!mdone && m_sz > 0) begin
                busy = 1;
            end
            if (w_valid) begin
                if (m_was_done) mext = 1;
                else if (m_sz == DEPTH && !m_pop) movf = 1;
                else q.push_back({w_pc, w_enable, w_destination, w_data});
            end
            if (m_pop) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pass_count", 32'(pass_count), 32'(mpass));
            chk("fail_count", 32'(fail_count), 32'(mfail));
            chk("mismatch", 32'(mismatch), 32'(mmm));
            chk("first_fail_idx", 32'(first_fail_idx), 32'(mffi));
            chk("overflow", 32'(overflow), 32'(movf));
            chk("extra_retire", 32'(extra_retire), 32'(mext));
            chk("done", 32'(done), 32'(mdone));
            chk("exp_rd", 32'(exp_rd), 32'(!mdone && !busy && q.size() > 0));
            chk("exp_addr", 32'(exp_addr), 32'(midx));
        end
    end

    function automatic logic [69:0] grec(input logic [31:0] pc, input logic en,
                                         input logic [4:0] rd, input logic [31:0] d);
        return {pc, d, en, rd};
    endfunction

    task automatic clr_mem();
        for (int i = 0; i < 64; i++) gmem[i] = grec(32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic retire(input logic [31:0] pc, input logic en,
                          input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        w_valid = 1'b1;
        w_pc = pc;
        w_enable = en;
        w_destination = rd;
        w_data = d;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            w_valid = 1'b0;
        end
    endtask

    task automatic rst();
        @(negedge clk);
        w_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_seq(input int n);
        for (int i = 0; i < n; i++)
            gmem[i] = grec(32'h2000 + 32'(4 * i), 1'b1, 5'(1 + i), 32'(i * 3));
    endtask

    task automatic retire_seq(input int i);
        retire(32'h2000 + 32'(4 * i), 1'b1, 5'(1 + i), 32'(i * 3));
    endtask

    initial begin
        clr_mem();
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        reset = 1'b0;
        chk("reset_pass", 32'(pass_count), 0);
        chk("reset_exp_rd", 32'(exp_rd), 0);

        // Single matching record, latency, then sentinel and extra retire
        clr_mem();
        gmem[0] = grec(32'h1000, 1'b1, 5'd5, 32'h2A);
        rst();
        retire(32'h1000, 1'b1, 5'd5, 32'h2A);
        gap(1);
        chk("t1_lat_e1", 32'(pass_count), 0);
        gap(1);
        chk("t1_lat_e2", 32'(pass_count), 0);
        gap(1);
        chk("t1_lat_pass", 32'(pass_count), 1);
        retire(32'h1004, 1'b1, 5'd1, 32'h0);
        gap(4);
        chk("t1_done", 32'(done), 1);
        chk("t1_fail", 32'(fail_count), 0);
        chk("t1_extra_before", 32'(extra_retire), 0);
        retire(32'h1008, 1'b1, 5'd2, 32'h1);
        gap(3);
        chk("t5_extra", 32'(extra_retire), 1);
        chk("t5_pass_hold", 32'(pass_count), 1);
        chk("t5_fail_hold", 32'(fail_count), 0);
        chk("t5_no_read", 32'(exp_rd), 0);

        // x0 data ignored; en=0 ignores rd and data
        clr_mem();
        gmem[0] = grec(32'h1004, 1'b1, 5'd0, 32'h0);
        gmem[1] = grec(32'h1008, 1'b0, 5'd0, 32'h0);
        rst();
        retire(32'h1004, 1'b1, 5'd0, 32'hDEAD);
        gap(3);
        retire(32'h1008, 1'b0, 5'd7, 32'h1234);
        gap(4);
        chk("t2a_pass", 32'(pass_count), 2);
        chk("t2a_mismatch", 32'(mismatch), 0);

        clr_mem();
        gmem[0] = grec(32'h1004, 1'b1, 5'd3, 32'h0);
        rst();
        retire(32'h1004, 1'b1, 5'd0, 32'hDEAD);
        gap(4);
        chk("t2b_fail", 32'(fail_count), 1);
        chk("t2b_ffi", 32'(first_fail_idx), 0);
        chk("t2b_mismatch", 32'(mismatch), 1);
        chk("t2b_pass", 32'(pass_count), 0);

        // Back-to-back burst of 20 overruns an 8-entry FIFO
        clr_mem();
        load_seq(20);
        rst();
        for (int i = 0; i < 20; i++) retire_seq(i);
        gap(50);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_pass_lt_n", 32'(pass_count < 20), 1);
        chk("t3_pass", 32'(pass_count), 15);
        chk("t3_fail", 32'(fail_count), 2);
        chk("t3_ffi", 32'(first_fail_idx), 15);

        // Spaced burst of 4: nothing dropped
        rst();
        for (int i = 0; i < 4; i++) begin
            retire_seq(i);
            gap(1);
        end
        gap(6);
        chk("t3b_overflow", 32'(overflow), 0);
        chk("t3b_pass", 32'(pass_count), 4);

        // Saturation of pass_count
        clr_mem();
        load_seq(18);
        rst();
        for (int i = 0; i < 18; i++) begin
            retire_seq(i);
            gap(1);
        end
        retire(32'h9000, 1'b0, 5'd0, 32'h0);
        gap(8);
        chk("tsat_pass", 32'(pass_count), CMAX);
        chk("tsat_fail", 32'(fail_count), 0);
        chk("tsat_done", 32'(done), 1);

        // Mismatch at record 2 of 5
        clr_mem();
        load_seq(5);
        gmem[2] = grec(32'h2008, 1'b1, 5'd3, 32'h99);
        rst();
        for (int i = 0; i < 5; i++) begin
            retire_seq(i);
            gap(1);
        end
        retire(32'h9000, 1'b0, 5'd0, 32'h0);
        gap(8);
        chk("t4_fail", 32'(fail_count), 1);
        chk("t4_ffi", 32'(first_fail_idx), 2);
        chk("t4_done", 32'(done), 1);
`ifdef WB_CHECK_HALT_ON_FAIL_EN
        chk("t4_pass_halt", 32'(pass_count), 2);
        chk("t4_extra_halt", 32'(extra_retire), 1);
`else
        chk("t4_pass", 32'(pass_count), 4);
        chk("t4_extra", 32'(extra_retire), 0);
`endif

        // Reset mid-run discards everything
        clr_mem();
        load_seq(6);
        rst();
        retire_seq(0);
        gap(1);
        retire_seq(1);
        gap(1);
        retire_seq(2);
        gap(1);
        retire_seq(3);
        chk("t6_pre_pass", 32'(pass_count), 2);
        rst();
        chk("t6_pass0", 32'(pass_count), 0);
        chk("t6_fail0", 32'(fail_count), 0);
        chk("t6_mm0", 32'(mismatch), 0);
        chk("t6_ffi0", 32'(first_fail_idx), 0);
        chk("t6_ovf0", 32'(overflow), 0);
        chk("t6_extra0", 32'(extra_retire), 0);
        chk("t6_done0", 32'(done), 0);
        chk("t6_rd0", 32'(exp_rd), 0);
        chk("t6_addr0", 32'(exp_addr), 0);
        retire_seq(0);
        gap(1);
        chk("t6_rd_restart", 32'(exp_rd), 1);
        chk("t6_addr_restart", 32'(exp_addr), 0);
        gap(3);
        chk("t6_pass_restart", 32'(pass_count), 1);

        gap(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
